// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the audio frame buffer slice.
//   SAMPLE_W    - default sample width
//   FRAME_DEPTH - default samples per frame
//   DROP_CNT_W  - width of the dropped-frame counter
//   rd_state_e  - read-side handshake state encoding
package audio_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int FRAME_DEPTH = 256;
  localparam int DROP_CNT_W  = 16;

  typedef enum logic {
    RD_EMPTY = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

endpackage

// File: rtl/audio_pingpong_ram.sv
// audio_pingpong_ram: simple dual-port RAM holding both frame banks.
// Kept separate so the array maps cleanly onto a block RAM.
//   clk, rst   - clock, async active-low reset (read register only)
//   we, waddr, wdata - write port, address = {bank, index}
//   raddr      - read address = {bank, index}
//   rdata      - registered read data (1-cycle latency)
module audio_pingpong_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(2 * DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2 * DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: collects the sample stream into ping-pong frame banks
// and presents each completed frame to a consumer via valid/done handshake.
//   clk, rst       - clock, async active-low reset
//   en             - capture enable; low rewinds the write index
//   sample_stb     - one-cycle strobe qualifying sample
//   sample         - incoming sample
//   frame_valid    - a completed frame is readable
//   frame_done     - consumer releases the presented frame
//   rd_addr        - read index within presented frame (0 = oldest)
//   rd_data        - registered read data
//   overrun        - sticky dropped-frame flag
//   clear_overrun  - clears overrun and drop_count
//   drop_count     - saturating dropped-frame count
//
// state    | meaning
// RD_EMPTY | no frame presented; next completed frame is accepted
// RD_VALID | read_bank holds a frame owned by the consumer
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter  int WIDTH      = SAMPLE_W,
  parameter  int DEPTH      = FRAME_DEPTH,
  parameter  int SIGNED_OUT = 0,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample_stb,
  input  logic [WIDTH-1:0]      sample,
  output logic                  frame_valid,
  input  logic                  frame_done,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // The MSB flip is applied on the way into the RAM so the registered
  // read data (and its reset value of 0) needs no extra output stage.
  localparam logic [WIDTH-1:0] OUT_XOR =
    (SIGNED_OUT != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  rd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     wr_idx_q, wr_idx_d;
  logic                  fill_bank_q, fill_bank_d;
  logic                  read_bank_q, read_bank_d;
  logic                  overrun_q, overrun_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic wr_fire;
  logic frame_complete;
  logic frame_accept;
  logic frame_drop;

  always_comb begin
    wr_fire        = en & sample_stb;
    frame_complete = wr_fire && (wr_idx_q == ADDR_W'(DEPTH - 1));
    frame_accept   = frame_complete && ((state_q == RD_EMPTY) || frame_done);
    frame_drop     = frame_complete && !frame_accept;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RD_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_EMPTY: if (frame_accept) state_d = RD_VALID;
      RD_VALID: begin
        if (frame_accept)    state_d = RD_VALID;
        else if (frame_done) state_d = RD_EMPTY;
      end
      default: state_d = RD_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_valid = (state_q == RD_VALID);
  end

  // Bank control, write index and overrun accounting
  always_comb begin
    wr_idx_d     = wr_idx_q;
    fill_bank_d  = fill_bank_q;
    read_bank_d  = read_bank_q;
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;

    if (!en) begin
      wr_idx_d = '0;
    end else if (sample_stb) begin
      // Wraps to 0 at DEPTH-1; on a drop the fill bank is simply rewritten.
      wr_idx_d = wr_idx_q + ADDR_W'(1);
    end

    if (frame_accept) begin
      read_bank_d = fill_bank_q;
      fill_bank_d = ~fill_bank_q;
    end

    // A drop in the same cycle as clear_overrun counts as the first new drop.
    if (frame_drop) begin
      overrun_d = 1'b1;
      if (clear_overrun) begin
        drop_count_d = DROP_CNT_W'(1);
      end else if (drop_count_q != {DROP_CNT_W{1'b1}}) begin
        drop_count_d = drop_count_q + DROP_CNT_W'(1);
      end
    end else if (clear_overrun) begin
      overrun_d    = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q     <= '0;
      fill_bank_q  <= 1'b0;
      read_bank_q  <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      fill_bank_q  <= fill_bank_d;
      read_bank_q  <= read_bank_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  audio_pingpong_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr ({fill_bank_q, wr_idx_q}),
    .wdata (sample ^ OUT_XOR),
    .raddr ({read_bank_q, rd_addr}),
    .rdata (rd_data)
  );

  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;

endmodule
